// File: rtl/st7735_spi_sink_if.sv
// Bundle between an ST7735 SPI driver and the panel-side sink: the SPI pins in one
// direction and the decoded byte stream in the other.
interface st7735_spi_sink_if #(
  parameter int PIDX_W = 5
);
  logic              CS;
  logic              LCD_CLK;
  logic              MOSI;
  logic              DC;
  logic              LCD_RST;
  logic              BYTE_VALID;
  logic [7:0]        BYTE_DATA;
  logic              BYTE_IS_CMD;
  logic [7:0]        CMD_CODE;
  logic [PIDX_W-1:0] PARAM_INDEX;
  logic              STRAY_DATA;
  logic              FRAME_ERR;
  logic              BUSY;

  modport master (
    output CS, LCD_CLK, MOSI, DC, LCD_RST,
    input  BYTE_VALID, BYTE_DATA, BYTE_IS_CMD, CMD_CODE, PARAM_INDEX,
           STRAY_DATA, FRAME_ERR, BUSY
  );

  modport slave (
    input  CS, LCD_CLK, MOSI, DC, LCD_RST,
    output BYTE_VALID, BYTE_DATA, BYTE_IS_CMD, CMD_CODE, PARAM_INDEX,
           STRAY_DATA, FRAME_ERR, BUSY
  );
endinterface

// File: rtl/st7735_spi_sink.sv
// ST7735 4-wire SPI receiver: oversamples the bus on SYSTEM_CLK, deserialises bytes
// MSB-first and tags them as command or parameter with a running parameter index.
module st7735_spi_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int PIDX_W      = 5
) (
  input logic               SYSTEM_CLK,
  input logic               RESET,
  st7735_spi_sink_if.slave  bus
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam int         STAGES  = 1;
  // {lcd_rst, dc, mosi, lcd_clk, cs}: CS and LCD_CLK come out of reset at their idle-high level
  localparam logic [4:0] SYNC_INIT = 5'b00011;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic cs_s, sck_s, mosi_s, dc_s, rst_s;
  logic sck_d, sck_rise;

  always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= {SYNC_STAGES{SYNC_INIT}};
      sck_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0],
                 {bus.LCD_RST, bus.DC, bus.MOSI, bus.LCD_CLK, bus.CS}};
      sck_d  <= sck_s;
    end
  end

  assign cs_s     = sync_q[SYNC_STAGES-1][0];
  assign sck_s    = sync_q[SYNC_STAGES-1][1];
  assign mosi_s   = sync_q[SYNC_STAGES-1][2];
  assign dc_s     = sync_q[SYNC_STAGES-1][3];
  assign rst_s    = sync_q[SYNC_STAGES-1][4];
  assign sck_rise = sck_s & ~sck_d;

  logic [0:0]      state;
  logic [2:0]      bit_cnt;
  logic [6:0]      shreg;
  logic [7:0]      cap_byte;
  logic            cap_cmd;
  logic [STAGES:0] vld_pipe;
  logic            frame_err_q;
  logic            byte_done;

  // The 8th rising edge completes the byte even if CS rose in the same sampled cycle.
  assign byte_done = (state == S_SHIFT) && sck_rise && (bit_cnt == 3'd7) && !rst_s;

  always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      cap_byte    <= '0;
      cap_cmd     <= 1'b0;
      vld_pipe    <= '0;
      frame_err_q <= 1'b0;
    end else if (rst_s) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      vld_pipe    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:0], byte_done};
      frame_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (!cs_s) state <= S_SHIFT;
        end
        default: begin
          if (sck_rise && !cs_s) begin
            shreg   <= {shreg[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (byte_done) begin
            cap_byte <= {shreg, mosi_s};
            cap_cmd  <= ~dc_s;
          end
          if (cs_s) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            frame_err_q <= (bit_cnt != 3'd0) && !byte_done;
          end
        end
      endcase
    end
  end

  logic              byte_valid, byte_is_cmd, stray_data, frame_err, cmd_seen;
  logic [7:0]        byte_data, cmd_code;
  logic [PIDX_W-1:0] param_index;

  always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
    if (RESET) begin
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      byte_is_cmd <= 1'b0;
      cmd_code    <= '0;
      param_index <= '0;
      stray_data  <= 1'b0;
      frame_err   <= 1'b0;
      cmd_seen    <= 1'b0;
    end else if (rst_s) begin
      byte_valid  <= 1'b0;
      stray_data  <= 1'b0;
      frame_err   <= 1'b0;
      cmd_seen    <= 1'b0;
      cmd_code    <= '0;
      param_index <= '0;
    end else begin
      byte_valid <= vld_pipe[STAGES];
      stray_data <= 1'b0;
      frame_err  <= frame_err_q;
      if (vld_pipe[STAGES]) begin
        byte_data   <= cap_byte;
        byte_is_cmd <= cap_cmd;
        if (cap_cmd) begin
          cmd_code    <= cap_byte;
          param_index <= '0;
          cmd_seen    <= 1'b1;
        end else begin
          if (param_index != '1) param_index <= param_index + 1'b1;
          stray_data <= ~cmd_seen;
        end
      end
    end
  end

  assign bus.BYTE_VALID  = byte_valid;
  assign bus.BYTE_DATA   = byte_data;
  assign bus.BYTE_IS_CMD = byte_is_cmd;
  assign bus.CMD_CODE    = cmd_code;
  assign bus.PARAM_INDEX = param_index;
  assign bus.STRAY_DATA  = stray_data;
  assign bus.FRAME_ERR   = frame_err;
  assign bus.BUSY        = (state == S_SHIFT);
endmodule

// File: tb/tb_st7735_spi_sink.sv
// Bench for st7735_spi_sink: table of SPI bytes with expected decode, scoreboard-checked,
// plus hand sequences for framing errors, CS/SCK coincidence, latency and resets.
module tb_st7735_spi_sink;
  localparam int SS = 2;
  localparam int PW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  st7735_spi_sink_if #(.PIDX_W(PW)) bus();
  st7735_spi_sink #(.SYNC_STAGES(SS), .PIDX_W(PW)) dut (
    .SYSTEM_CLK(clk), .RESET(rst), .bus(bus)
  );

  typedef struct {
    logic          dc;
    logic [7:0]    data;
    logic          keep;
    logic [7:0]    exp_cmd;
    logic [PW-1:0] exp_pidx;
    logic          exp_stray;
  } vec_t;

  typedef struct {
    logic [7:0]    data;
    logic          is_cmd;
    logic [PW-1:0] pidx;
    logic [7:0]    cmd;
    logic          stray;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[8];
  int errors = 0, checks = 0, n_valid = 0, n_ferr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.FRAME_ERR) n_ferr++;
    if (bus.BYTE_VALID) begin
      n_valid++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got data %0h expected no byte", bus.BYTE_DATA);
      end else begin
        e = sb.pop_front();
        chk("byte_data",   bus.BYTE_DATA,   e.data);
        chk("byte_is_cmd", bus.BYTE_IS_CMD, e.is_cmd);
        chk("param_index", bus.PARAM_INDEX, e.pidx);
        chk("cmd_code",    bus.CMD_CODE,    e.cmd);
        chk("stray_data",  bus.STRAY_DATA,  e.stray);
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic c, input logic [PW-1:0] p,
                      input logic [7:0] cc, input logic s);
    exp_t x;
    x.data = d; x.is_cmd = c; x.pidx = p; x.cmd = cc; x.stray = s;
    sb.push_back(x);
  endtask

  task automatic send_bits(input logic dc, input logic [7:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.LCD_CLK = 1'b0;
      bus.MOSI    = d[7-i];
      bus.DC      = dc;
      #40;
      bus.LCD_CLK = 1'b1;
      #40;
    end
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] d);
    bus.CS = 1'b0; #40;
    send_bits(dc, d, 8);
    bus.CS = 1'b1; #80;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  int v0, f0, lat;
  logic in_frame;

  initial begin
    bus.CS = 1'b1; bus.LCD_CLK = 1'b1; bus.MOSI = 1'b0; bus.DC = 1'b0; bus.LCD_RST = 1'b0;

    tbl[0] = '{1'b1, 8'hAA, 1'b0, 8'h00, 5'd1, 1'b1};
    tbl[1] = '{1'b0, 8'h11, 1'b0, 8'h11, 5'd0, 1'b0};
    tbl[2] = '{1'b0, 8'hB1, 1'b0, 8'hB1, 5'd0, 1'b0};
    tbl[3] = '{1'b1, 8'h01, 1'b0, 8'hB1, 5'd1, 1'b0};
    tbl[4] = '{1'b1, 8'h2C, 1'b0, 8'hB1, 5'd2, 1'b0};
    tbl[5] = '{1'b1, 8'h2D, 1'b0, 8'hB1, 5'd3, 1'b0};
    tbl[6] = '{1'b0, 8'h36, 1'b1, 8'h36, 5'd0, 1'b0};
    tbl[7] = '{1'b1, 8'h48, 1'b0, 8'h36, 5'd1, 1'b0};

    #12;
    chk("rst_byte_valid", bus.BYTE_VALID, 0);
    chk("rst_byte_data",  bus.BYTE_DATA, 0);
    chk("rst_cmd_code",   bus.CMD_CODE, 0);
    chk("rst_pidx",       bus.PARAM_INDEX, 0);
    chk("rst_busy",       bus.BUSY, 0);
    chk("rst_frame_err",  bus.FRAME_ERR, 0);
    chk("rst_stray",      bus.STRAY_DATA, 0);
    #8 rst = 1'b0;
    #40;

    in_frame = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!in_frame) begin bus.CS = 1'b0; #40; end
      push(tbl[i].data, ~tbl[i].dc, tbl[i].exp_pidx, tbl[i].exp_cmd, tbl[i].exp_stray);
      send_bits(tbl[i].dc, tbl[i].data, 8);
      in_frame = tbl[i].keep;
      if (!in_frame) begin bus.CS = 1'b1; #80; end
      wait_drain("table_drain");
    end
    chk("table_no_ferr", n_ferr, 0);

    // partial byte then CS high
    v0 = n_valid; f0 = n_ferr;
    bus.CS = 1'b0; #40;
    send_bits(1'b0, 8'hF0, 5);
    bus.CS = 1'b1; #200;
    chk("partial_ferr_once", n_ferr - f0, 1);
    chk("partial_no_valid",  n_valid - v0, 0);
    push(8'h29, 1'b1, 5'd0, 8'h29, 1'b0);
    send_byte(1'b0, 8'h29);
    wait_drain("after_ferr_drain");

    // index saturation
    push(8'hE0, 1'b1, 5'd0, 8'hE0, 1'b0);
    send_byte(1'b0, 8'hE0);
    for (int i = 1; i <= 40; i++) begin
      push(8'(i * 3), 1'b0, (i > 31) ? 5'd31 : 5'(i), 8'hE0, 1'b0);
      send_byte(1'b1, 8'(i * 3));
    end
    wait_drain("sat_drain");
    chk("sat_pidx_hold", bus.PARAM_INDEX, 31);
    push(8'h2A, 1'b1, 5'd0, 8'h2A, 1'b0);
    send_byte(1'b0, 8'h2A);
    wait_drain("pidx_reset_drain");

    // CS rises together with the 8th clock edge
    f0 = n_ferr;
    push(8'h5A, 1'b0, 5'd1, 8'h2A, 1'b0);
    bus.CS = 1'b0; #40;
    send_bits(1'b1, 8'h5A, 7);
    bus.LCD_CLK = 1'b0; bus.MOSI = 1'b0; #40;
    bus.LCD_CLK = 1'b1; bus.CS = 1'b1; #80;
    wait_drain("coincident_drain");
    chk("coincident_no_ferr", n_ferr - f0, 0);

    // latency from the first edge sampling the 8th clock high
    push(8'hC0, 1'b1, 5'd0, 8'hC0, 1'b0);
    bus.CS = 1'b0; #40;
    send_bits(1'b0, 8'hC0, 7);
    bus.LCD_CLK = 1'b0; bus.MOSI = 1'b0; #40;
    @(negedge clk); bus.LCD_CLK = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (bus.BYTE_VALID && lat < 0) lat = n;
    end
    chk("latency", lat, SS + 2);
    bus.CS = 1'b1; #80;
    wait_drain("latency_drain");

    // panel reset pin mid-byte
    v0 = n_valid; f0 = n_ferr;
    bus.CS = 1'b0; #40;
    send_bits(1'b1, 8'hFF, 4);
    bus.LCD_RST = 1'b1; #100;
    chk("lcdrst_busy", bus.BUSY, 0);
    chk("lcdrst_cmd",  bus.CMD_CODE, 0);
    chk("lcdrst_pidx", bus.PARAM_INDEX, 0);
    bus.CS = 1'b1; #100;
    bus.LCD_RST = 1'b0; #100;
    chk("lcdrst_no_valid", n_valid - v0, 0);
    chk("lcdrst_no_ferr",  n_ferr - f0, 0);

    // block reset mid-byte
    bus.CS = 1'b0; #40;
    send_bits(1'b0, 8'hFF, 3);
    rst = 1'b1; #20;
    chk("hardrst_busy",   bus.BUSY, 0);
    chk("hardrst_data",   bus.BYTE_DATA, 0);
    chk("hardrst_is_cmd", bus.BYTE_IS_CMD, 0);
    rst = 1'b0; #100;
    bus.CS = 1'b1; #100;
    chk("hardrst_no_valid", n_valid - v0, 0);
    chk("hardrst_no_ferr",  n_ferr - f0, 0);
    push(8'h77, 1'b0, 5'd1, 8'h00, 1'b1);
    send_byte(1'b1, 8'h77);
    wait_drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
